// File: rtl/bdi_pkg.sv
// Shared types and widths for the Base-Delta-Immediate line decompressor.
package bdi_pkg;

  localparam int unsigned WORDS  = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned LINE_W = WORDS * WORD_W;
  localparam int unsigned BASE_W = 32;
  localparam int unsigned D1_W   = 8;
  localparam int unsigned D2_W   = 16;
  localparam int unsigned ENC_W  = 3;
  localparam int unsigned IDX_W  = 3;

  typedef enum logic [ENC_W-1:0] {
    ENC_ZEROS  = 3'd0,
    ENC_REPEAT = 3'd1,
    ENC_B4D1   = 3'd2,
    ENC_B4D2   = 3'd3,
    ENC_RAW    = 3'd4
  } bdi_enc_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_ERR  = 2'd2
  } bdi_dec_state_t;

  // Encodings above RAW are reserved and flagged as errors.
  function automatic logic enc_legal(input logic [ENC_W-1:0] enc);
    return enc <= ENC_W'(ENC_RAW);
  endfunction

endpackage

// File: rtl/bdi_word_decode.sv
// Reconstructs one 32-bit word of a BDI-compressed line from its encoding,
// base-select bit, payload and word index.
module bdi_word_decode
  import bdi_pkg::*;
(
  input  logic [ENC_W-1:0]  i_enc,
  input  logic              i_mask_bit,
  input  logic [LINE_W-1:0] i_payload,
  input  logic [IDX_W-1:0]  i_idx,
  output logic [WORD_W-1:0] o_word
);

  logic [WORD_W-1:0] w_base;
  logic [WORD_W-1:0] w_sel_base;
  logic [D1_W-1:0]   w_d1;
  logic [D2_W-1:0]   w_d2;
  logic [WORD_W-1:0] w_d1_sext;
  logic [WORD_W-1:0] w_d2_sext;
  logic [WORD_W-1:0] w_raw;

  assign w_base     = i_payload[BASE_W-1:0];
  assign w_sel_base = i_mask_bit ? w_base : '0;
  assign w_d1       = i_payload[BASE_W + D1_W*i_idx +: D1_W];
  assign w_d2       = i_payload[BASE_W + D2_W*i_idx +: D2_W];
  assign w_d1_sext  = {{(WORD_W-D1_W){w_d1[D1_W-1]}}, w_d1};
  assign w_d2_sext  = {{(WORD_W-D2_W){w_d2[D2_W-1]}}, w_d2};
  assign w_raw      = i_payload[WORD_W*i_idx +: WORD_W];

  // Sums wrap modulo 2^32; illegal encodings decode to zero.
  always_comb begin
    o_word = '0;
    case (i_enc)
      ENC_ZEROS:  o_word = '0;
      ENC_REPEAT: o_word = w_base;
      ENC_B4D1:   o_word = w_sel_base + w_d1_sext;
      ENC_B4D2:   o_word = w_sel_base + w_d2_sext;
      ENC_RAW:    o_word = w_raw;
      default:    o_word = '0;
    endcase
  end

endmodule

// File: rtl/bdi_decompressor.sv
// BDI line decompressor: captures one compressed line and streams its eight
// reconstructed words under a valid/ready handshake.
module bdi_decompressor
  import bdi_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ENC_W-1:0]  in_encoding,
  input  logic [WORDS-1:0]  in_mask,
  input  logic [LINE_W-1:0] in_payload,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              out_error
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  bdi_dec_state_t    r_state;
  logic [ENC_W-1:0]  r_enc;
  logic [WORDS-1:0]  r_mask;
  logic [LINE_W-1:0] r_payload;
  logic [IDX_W-1:0]  r_idx;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_out_last;
  logic              r_out_error;
  logic [WORD_W-1:0] w_word;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_enc       <= '0;
      r_mask      <= '0;
      r_payload   <= '0;
      r_idx       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_error <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_enc       <= in_encoding;
            r_mask      <= in_mask;
            r_payload   <= in_payload;
            r_idx       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b1;
            if (enc_legal(in_encoding)) begin
              r_state     <= ST_EMIT;
              r_out_last  <= 1'b0;
              r_out_error <= 1'b0;
            end else begin
              r_state     <= ST_ERR;
              r_out_last  <= 1'b1;
              r_out_error <= 1'b1;
            end
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            if (r_idx == LAST_IDX) begin
              r_state     <= ST_IDLE;
              r_idx       <= '0;
              r_in_ready  <= 1'b1;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
            end else begin
              r_idx      <= r_idx + IDX_W'(1);
              r_out_last <= (r_idx == LAST_IDX - IDX_W'(1));
            end
          end
        end
        ST_ERR: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_error <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_idx       <= '0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
          r_out_error <= 1'b0;
        end
      endcase
    end
  end

  // Word is decoded straight from the captured line and current index.
  bdi_word_decode u_word_decode (
    .i_enc      (r_enc),
    .i_mask_bit (r_mask[r_idx]),
    .i_payload  (r_payload),
    .i_idx      (r_idx),
    .o_word     (w_word)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_word  = w_word;
  assign out_idx   = r_idx;
  assign out_last  = r_out_last;
  assign out_error = r_out_error;

endmodule

// File: tb/tb_bdi_decompressor.sv
// Self-checking bench for bdi_decompressor: table vectors, corner sequences
// and random lines checked against an arithmetic reference model.
module tb_bdi_decompressor;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_encoding;
  logic [7:0]   in_mask;
  logic [255:0] in_payload;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_word;
  logic [2:0]   out_idx;
  logic         out_last;
  logic         out_error;

  int errors = 0;
  int checks = 0;

  bdi_decompressor dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_encoding (in_encoding),
    .in_mask     (in_mask),
    .in_payload  (in_payload),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_word    (out_word),
    .out_idx     (out_idx),
    .out_last    (out_last),
    .out_error   (out_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string        name;
    logic [2:0]   enc;
    logic [7:0]   mask;
    logic [255:0] pl;
    logic [255:0] exp_w;
  } vec_t;

  vec_t tab [6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Reference: expected words from the encoding rules using signed integer arithmetic.
  function automatic logic [255:0] model_line(input logic [2:0] enc, input logic [7:0] mask,
                                              input logic [255:0] pl);
    logic [255:0] r;
    logic [255:0] sh;
    longint       base;
    longint       d;
    longint       v;
    r    = '0;
    base = longint'(pl[31:0]);
    for (int i = 0; i < 8; i++) begin
      v = 0;
      case (enc)
        3'd0: v = 0;
        3'd1: v = base;
        3'd2: begin
          sh = pl >> (32 + 8 * i);
          d  = longint'(sh[7:0]);
          if (d >= 128) d = d - 256;
          v  = (mask[i] ? base : 0) + d;
        end
        3'd3: begin
          sh = pl >> (32 + 16 * i);
          d  = longint'(sh[15:0]);
          if (d >= 32768) d = d - 65536;
          v  = (mask[i] ? base : 0) + d;
        end
        3'd4: begin
          sh = pl >> (32 * i);
          v  = longint'(sh[31:0]);
        end
        default: v = 0;
      endcase
      r[32*i +: 32] = v[31:0];
    end
    return r;
  endfunction

  // Sends one line and checks every cycle of its output stream.
  task automatic run_line(input logic [2:0] enc, input logic [7:0] mask, input logic [255:0] pl,
                          input logic [255:0] expw, input bit rnd_rdy, input bit junk,
                          input bit chk_lat, input string tag);
    int nbeats;
    int k;
    int cyc;
    bit hs;
    bit legal;
    legal  = (enc <= 3'd4);
    nbeats = legal ? 8 : 1;
    k      = 0;
    check({tag, " in_ready_before"}, 32'(in_ready), 32'd1);
    in_valid    = 1'b1;
    in_encoding = enc;
    in_mask     = mask;
    in_payload  = pl;
    out_ready   = 1'b1;
    step();
    cyc = 1;
    in_valid    = 1'b0;
    in_encoding = 3'($urandom);
    in_mask     = 8'($urandom);
    in_payload  = rand256();
    check({tag, " first_valid"}, 32'(out_valid), 32'd1);
    while (k < nbeats && cyc < 200) begin
      if (out_valid !== 1'b1) begin
        check({tag, " valid_dropped"}, 32'(out_valid), 32'd1);
        break;
      end
      check({tag, " word"}, out_word, expw[32*k +: 32]);
      check({tag, " idx"}, 32'(out_idx), legal ? 32'(k) : 32'd0);
      check({tag, " last"}, 32'(out_last), 32'(k == nbeats - 1));
      check({tag, " error"}, 32'(out_error), 32'(!legal));
      check({tag, " in_ready_busy"}, 32'(in_ready), 32'd0);
      out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (junk && k < nbeats - 1) begin
        in_valid    = 1'($urandom);
        in_encoding = 3'($urandom);
        in_mask     = 8'($urandom);
        in_payload  = rand256();
      end else begin
        in_valid = 1'b0;
      end
      hs = out_ready;
      step();
      cyc++;
      if (hs) k++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check({tag, " beats_done"}, 32'(k), 32'(nbeats));
    check({tag, " in_ready_after"}, 32'(in_ready), 32'd1);
    check({tag, " valid_after"}, 32'(out_valid), 32'd0);
    if (chk_lat) check({tag, " ready_return_cycle"}, 32'(cyc), 32'(nbeats + 1));
  endtask

  initial begin
    logic [255:0] pl;
    logic [255:0] expw;
    logic [2:0]   enc;
    logic [7:0]   mask;
    int           guard;

    tab[0] = '{"zeros", 3'd0, 8'hFF, {256{1'b1}}, 256'h0};
    tab[1] = '{"repeat", 3'd1, 8'h00, {224'h1234_5678_9ABC_DEF0_0BAD_F00D_CAFE, 32'hDEADBEEF},
               {8{32'hDEADBEEF}}};
    tab[2] = '{"b4d1", 3'd2, 8'hFF, {{160{1'b1}}, 64'h3020_10FF_807F_0100, 32'h1000_0000},
               {32'h10000030, 32'h10000020, 32'h10000010, 32'h0FFFFFFF,
                32'h0FFFFF80, 32'h1000007F, 32'h10000001, 32'h10000000}};
    tab[3] = '{"b4d2", 3'd3, 8'h01, {192'h0, 16'h8000, 16'h0020, 32'hFFFF_FFF0},
               {192'h0, 32'hFFFF8000, 32'h00000010}};
    tab[4] = '{"b4d1_mixed", 3'd2, 8'h0F, {160'h0, 64'h0102_0304_FEFD_FCFB, 32'h0000_0100},
               {32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004,
                32'h000000FE, 32'h000000FD, 32'h000000FC, 32'h000000FB}};
    tab[5] = '{"illegal6", 3'd6, 8'hFF, {256{1'b1}}, 256'h0};

    rst         = 1'b0;
    in_valid    = 1'b0;
    in_encoding = '0;
    in_mask     = '0;
    in_payload  = '0;
    out_ready   = 1'b1;
    repeat (3) step();
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_word", out_word, 32'd0);
    check("reset out_idx", 32'(out_idx), 32'd0);
    check("reset out_last", 32'(out_last), 32'd0);
    check("reset out_error", 32'(out_error), 32'd0);
    rst = 1'b1;
    step();

    for (int i = 0; i < 6; i++)
      run_line(tab[i].enc, tab[i].mask, tab[i].pl, tab[i].exp_w, 1'b0, 1'b0, 1'b1, tab[i].name);

    // RAW line with back-pressure and spurious in_valid during emission.
    for (int n = 0; n < 3; n++) begin
      pl = rand256();
      run_line(3'd4, 8'($urandom), pl, pl, 1'b1, 1'b1, 1'b0, "raw_stall");
    end

    // Asynchronous reset while beat 3 of a RAW line is on the output.
    pl = rand256();
    in_valid    = 1'b1;
    in_encoding = 3'd4;
    in_mask     = 8'hA5;
    in_payload  = pl;
    out_ready   = 1'b1;
    step();
    in_valid = 1'b0;
    guard    = 0;
    while (out_idx != 3'd3 && guard < 20) begin
      step();
      guard++;
    end
    check("midrst reached_beat3", 32'(out_idx), 32'd3);
    check("midrst beat3_word", out_word, pl[127:96]);
    rst = 1'b0;
    #1;
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst in_ready", 32'(in_ready), 32'd1);
    check("midrst out_idx", 32'(out_idx), 32'd0);
    check("midrst out_last", 32'(out_last), 32'd0);
    check("midrst out_error", 32'(out_error), 32'd0);
    check("midrst out_word", out_word, 32'd0);
    step();
    rst = 1'b1;
    step();
    pl = rand256();
    run_line(3'd4, 8'h00, pl, pl, 1'b0, 1'b0, 1'b1, "post_rst_raw");

    // Random lines over every encoding, checked against the model.
    for (int n = 0; n < 24; n++) begin
      enc  = 3'($urandom_range(0, 7));
      mask = 8'($urandom);
      pl   = rand256();
      expw = model_line(enc, mask, pl);
      run_line(enc, mask, pl, expw, 1'b1, 1'b1, 1'b0, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
